// File: rtl/pcie_perst_seq_pkg.sv
// -----------------------------------------------------------------------------
// pcie_perst_seq_pkg
// Shared types and constants for the root-side PCIe PERST#/refclk sideband
// sequencer.
//   perst_state_t      : per-port sequencer state, encoding exposed on port_state
//   pcie_root2ep_sb_t  : root-to-endpoint sideband pin pair {perst_n, refclk_oe}
//   PERST_*_DEF        : default timing in sequencer clock cycles
//   perst_cnt_w()      : timer width able to hold the larger of the two delays
// -----------------------------------------------------------------------------
package pcie_perst_seq_pkg;

    typedef enum logic [2:0] {
        PERST_OFF      = 3'd0,
        PERST_CLK_WAIT = 3'd1,
        PERST_UP       = 3'd2,
        PERST_HOLD     = 3'd3,
        PERST_DOWN     = 3'd4
    } perst_state_t;

    typedef struct packed {
        logic perst_n;
        logic refclk_oe;
    } pcie_root2ep_sb_t;

    localparam int PERST_T_CLK_STABLE_DEF = 100;
    localparam int PERST_T_MIN_DEF        = 100;

    // Width needed to hold max(a, b) as an unsigned count.
    function automatic int perst_cnt_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pcie_perst_port_fsm.sv
// -----------------------------------------------------------------------------
// pcie_perst_port_fsm
// One endpoint port: state machine, down-counting timer and registered
// sideband outputs. All outputs reflect the registered state, so a decision
// taken on the inputs of cycle N is visible at cycle N+1.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_pwr_ok            board power-good, low forces the port off
//   i_port_en           port enable level
//   i_port_rst_req      warm-reset request pulse
//   i_lane_mask         lanes allowed to transmit while the port is up
//   o_perst_n           PERST# (active-low)
//   o_refclk_oe         reference clock buffer enable
//   o_lane_tx_en        SerDes TX enable per lane
//   o_port_up           port released from reset
//   o_port_state        encoded state (perst_state_t)
// -----------------------------------------------------------------------------
module pcie_perst_port_fsm
    import pcie_perst_seq_pkg::*;
#(
    parameter int LANES        = 8,
    parameter int T_CLK_STABLE = PERST_T_CLK_STABLE_DEF,
    parameter int T_PERST_MIN  = PERST_T_MIN_DEF,
    parameter int CNT_W        = perst_cnt_w(T_CLK_STABLE, T_PERST_MIN)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pwr_ok,
    input  logic             i_port_en,
    input  logic             i_port_rst_req,
    input  logic [LANES-1:0] i_lane_mask,
    output logic             o_perst_n,
    output logic             o_refclk_oe,
    output logic [LANES-1:0] o_lane_tx_en,
    output logic             o_port_up,
    output logic [2:0]       o_port_state
);

    localparam logic [CNT_W-1:0] C_T_CLK  = CNT_W'(T_CLK_STABLE);
    localparam logic [CNT_W-1:0] C_T_MIN  = CNT_W'(T_PERST_MIN);
    localparam logic [CNT_W-1:0] C_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

    perst_state_t       r_state;
    perst_state_t       w_state_nxt;
    logic [CNT_W-1:0]   r_timer;
    logic [CNT_W-1:0]   w_timer_nxt;
    logic [CNT_W-1:0]   w_timer_dec;
    logic               w_timer_done;

    pcie_root2ep_sb_t   r_sb;
    pcie_root2ep_sb_t   w_sb_nxt;
    logic [LANES-1:0]   r_lane_tx_en;
    logic [LANES-1:0]   w_lane_tx_en_nxt;
    logic               r_port_up;
    logic               w_port_up_nxt;

    assign w_timer_done = (r_timer == C_ZERO);
    // Saturating decrement so a zero timer never wraps.
    assign w_timer_dec  = w_timer_done ? C_ZERO : (r_timer - C_ONE);

    // State, timer and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= PERST_OFF;
            r_timer      <= C_ZERO;
            r_sb         <= '{perst_n: 1'b0, refclk_oe: 1'b0};
            r_lane_tx_en <= {LANES{1'b0}};
            r_port_up    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_sb         <= w_sb_nxt;
            r_lane_tx_en <= w_lane_tx_en_nxt;
            r_port_up    <= w_port_up_nxt;
        end
    end

    // Next-state and timer logic; power loss overrides every other input.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        if (!i_pwr_ok) begin
            w_state_nxt = PERST_OFF;
            w_timer_nxt = C_ZERO;
        end else begin
            case (r_state)
                PERST_OFF: begin
                    if (i_port_en) begin
                        w_state_nxt = PERST_CLK_WAIT;
                        w_timer_nxt = C_T_CLK;
                    end else begin
                        w_state_nxt = PERST_OFF;
                        w_timer_nxt = C_ZERO;
                    end
                end
                PERST_CLK_WAIT: begin
                    if (!i_port_en) begin
                        w_state_nxt = PERST_OFF;
                        w_timer_nxt = C_ZERO;
                    end else if (w_timer_done) begin
                        w_state_nxt = PERST_UP;
                        w_timer_nxt = C_ZERO;
                    end else begin
                        w_timer_nxt = w_timer_dec;
                    end
                end
                PERST_UP: begin
                    // Disable wins over a coincident warm-reset request.
                    if (!i_port_en) begin
                        w_state_nxt = PERST_DOWN;
                        w_timer_nxt = C_T_MIN;
                    end else if (i_port_rst_req) begin
                        w_state_nxt = PERST_HOLD;
                        w_timer_nxt = C_T_MIN;
                    end else begin
                        w_state_nxt = PERST_UP;
                    end
                end
                PERST_HOLD: begin
                    // PERST# is already low, so the running hold time counts
                    // toward the shutdown minimum.
                    if (!i_port_en) begin
                        w_state_nxt = PERST_DOWN;
                        w_timer_nxt = w_timer_dec;
                    end else if (i_port_rst_req) begin
                        w_timer_nxt = C_T_MIN;
                    end else if (w_timer_done) begin
                        w_state_nxt = PERST_UP;
                    end else begin
                        w_timer_nxt = w_timer_dec;
                    end
                end
                PERST_DOWN: begin
                    if (w_timer_done) begin
                        w_state_nxt = PERST_OFF;
                    end else begin
                        w_timer_nxt = w_timer_dec;
                    end
                end
                default: begin
                    w_state_nxt = PERST_OFF;
                    w_timer_nxt = C_ZERO;
                end
            endcase
        end
    end

    // Output decode from the next state so outputs line up with r_state.
    always_comb begin
        w_sb_nxt         = '{perst_n: 1'b0, refclk_oe: 1'b0};
        w_lane_tx_en_nxt = {LANES{1'b0}};
        w_port_up_nxt    = 1'b0;
        case (w_state_nxt)
            PERST_OFF: begin
                w_sb_nxt = '{perst_n: 1'b0, refclk_oe: 1'b0};
            end
            PERST_CLK_WAIT, PERST_HOLD, PERST_DOWN: begin
                w_sb_nxt = '{perst_n: 1'b0, refclk_oe: 1'b1};
            end
            PERST_UP: begin
                w_sb_nxt         = '{perst_n: 1'b1, refclk_oe: 1'b1};
                w_lane_tx_en_nxt = i_lane_mask;
                w_port_up_nxt    = 1'b1;
            end
            default: begin
                w_sb_nxt = '{perst_n: 1'b0, refclk_oe: 1'b0};
            end
        endcase
    end

    assign o_perst_n    = r_sb.perst_n;
    assign o_refclk_oe  = r_sb.refclk_oe;
    assign o_lane_tx_en = r_lane_tx_en;
    assign o_port_up    = r_port_up;
    assign o_port_state = r_state;

endmodule

// File: rtl/pcie_perst_seq.sv
// -----------------------------------------------------------------------------
// pcie_perst_seq
// Root-side PCIe sideband sequencer: PERST# and refclk output-enable for
// NUM_PORTS independent endpoint ports, each with LANES lane TX enables.
// Ports (port-major vectors, port p occupies slice p):
//   clk, rst       clock, synchronous active-high reset
//   pwr_ok         board power-good
//   port_en        [NUM_PORTS]          per-port enable level
//   port_rst_req   [NUM_PORTS]          per-port warm-reset pulse
//   lane_mask      [NUM_PORTS*LANES]    per-port lane enable mask
//   perst_n        [NUM_PORTS]          PERST# (active-low)
//   refclk_oe      [NUM_PORTS]          refclk buffer enable
//   lane_tx_en     [NUM_PORTS*LANES]    SerDes TX enable
//   port_up        [NUM_PORTS]          port released from reset
//   port_state     [NUM_PORTS*3]        encoded per-port state
// -----------------------------------------------------------------------------
module pcie_perst_seq
    import pcie_perst_seq_pkg::*;
#(
    parameter int NUM_PORTS    = 2,
    parameter int LANES        = 8,
    parameter int T_CLK_STABLE = PERST_T_CLK_STABLE_DEF,
    parameter int T_PERST_MIN  = PERST_T_MIN_DEF,
    localparam int CNT_W       = perst_cnt_w(T_CLK_STABLE, T_PERST_MIN)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pwr_ok,
    input  logic [NUM_PORTS-1:0]       port_en,
    input  logic [NUM_PORTS-1:0]       port_rst_req,
    input  logic [NUM_PORTS*LANES-1:0] lane_mask,
    output logic [NUM_PORTS-1:0]       perst_n,
    output logic [NUM_PORTS-1:0]       refclk_oe,
    output logic [NUM_PORTS*LANES-1:0] lane_tx_en,
    output logic [NUM_PORTS-1:0]       port_up,
    output logic [NUM_PORTS*3-1:0]     port_state
);

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        pcie_perst_port_fsm #(
            .LANES        (LANES),
            .T_CLK_STABLE (T_CLK_STABLE),
            .T_PERST_MIN  (T_PERST_MIN),
            .CNT_W        (CNT_W)
        ) u_port (
            .i_clk          (clk),
            .i_rst          (rst),
            .i_pwr_ok       (pwr_ok),
            .i_port_en      (port_en[g]),
            .i_port_rst_req (port_rst_req[g]),
            .i_lane_mask    (lane_mask[g*LANES +: LANES]),
            .o_perst_n      (perst_n[g]),
            .o_refclk_oe    (refclk_oe[g]),
            .o_lane_tx_en   (lane_tx_en[g*LANES +: LANES]),
            .o_port_up      (port_up[g]),
            .o_port_state   (port_state[g*3 +: 3])
        );
    end

endmodule

// File: tb/tb_pcie_perst_seq.sv
// -----------------------------------------------------------------------------
// tb_pcie_perst_seq
// Directed self-checking bench for pcie_perst_seq with NUM_PORTS=2, LANES=8,
// T_CLK_STABLE=4, T_PERST_MIN=3. Inputs change and outputs are sampled 1 time
// unit after each rising edge; "cycle k" is the period after edge k.
// -----------------------------------------------------------------------------
module tb_pcie_perst_seq;

    localparam int NP = 2;
    localparam int LN = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            pwr_ok = 1'b0;
    logic [NP-1:0]   port_en = 2'b00;
    logic [NP-1:0]   port_rst_req = 2'b00;
    logic [NP*LN-1:0] lane_mask = 16'h0000;
    logic [NP-1:0]   perst_n;
    logic [NP-1:0]   refclk_oe;
    logic [NP*LN-1:0] lane_tx_en;
    logic [NP-1:0]   port_up;
    logic [NP*3-1:0] port_state;

    int n_checks = 0;
    int n_fail   = 0;

    pcie_perst_seq #(
        .NUM_PORTS    (NP),
        .LANES        (LN),
        .T_CLK_STABLE (4),
        .T_PERST_MIN  (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pwr_ok       (pwr_ok),
        .port_en      (port_en),
        .port_rst_req (port_rst_req),
        .lane_mask    (lane_mask),
        .perst_n      (perst_n),
        .refclk_oe    (refclk_oe),
        .lane_tx_en   (lane_tx_en),
        .port_up      (port_up),
        .port_state   (port_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pwr_ok = 1'b1; port_en = 2'b11;
        tick(); tick();
        if (perst_n !== 2'b00) begin $display("FAIL reset_perst_n got %b exp 00", perst_n); n_fail++; end
        n_checks++;
        if (refclk_oe !== 2'b00) begin $display("FAIL reset_refclk_oe got %b exp 00", refclk_oe); n_fail++; end
        n_checks++;
        if (lane_tx_en !== 16'h0000) begin $display("FAIL reset_lane_tx_en got %h exp 0000", lane_tx_en); n_fail++; end
        n_checks++;
        if (port_up !== 2'b00) begin $display("FAIL reset_port_up got %b exp 00", port_up); n_fail++; end
        n_checks++;
        if (port_state !== 6'o00) begin $display("FAIL reset_port_state got %o exp 00", port_state); n_fail++; end
        n_checks++;
        port_en = 2'b00; lane_mask = 16'h000F;
        rst = 1'b0;
        tick();
        if (port_state !== 6'o00) begin $display("FAIL idle_off_state got %o exp 00", port_state); n_fail++; end
        n_checks++;
    endtask

    task automatic test_power_up();
        port_en = 2'b01;                         // cycle N
        tick();                                  // N+1
        if (refclk_oe !== 2'b01) begin $display("FAIL pu_refclk_n1 got %b exp 01", refclk_oe); n_fail++; end
        n_checks++;
        if (port_state !== 6'o01) begin $display("FAIL pu_state_n1 got %o exp 01", port_state); n_fail++; end
        n_checks++;
        for (int i = 2; i <= 5; i++) begin
            tick();
            if (perst_n !== 2'b00) begin $display("FAIL pu_perst_low N+%0d got %b exp 00", i, perst_n); n_fail++; end
            n_checks++;
        end
        tick();                                  // N+6
        if (perst_n !== 2'b01) begin $display("FAIL pu_perst_n got %b exp 01", perst_n); n_fail++; end
        n_checks++;
        if (port_up !== 2'b01) begin $display("FAIL pu_port_up got %b exp 01", port_up); n_fail++; end
        n_checks++;
        if (port_state !== 6'o02) begin $display("FAIL pu_state got %o exp 02", port_state); n_fail++; end
        n_checks++;
        if (lane_tx_en !== 16'h000F) begin $display("FAIL pu_lane got %h exp 000f", lane_tx_en); n_fail++; end
        n_checks++;
    endtask

    task automatic test_lane_mask();
        lane_mask = 16'hFFFF;
        #1;
        if (lane_tx_en !== 16'h000F) begin $display("FAIL lm_same_cycle got %h exp 000f", lane_tx_en); n_fail++; end
        n_checks++;
        tick();
        if (lane_tx_en !== 16'h00FF) begin $display("FAIL lm_next_cycle got %h exp 00ff", lane_tx_en); n_fail++; end
        n_checks++;
    endtask

    task automatic test_warm_reset();
        port_rst_req = 2'b01;                    // cycle M
        tick(); port_rst_req = 2'b00;            // M+1
        if (port_state !== 6'o03) begin $display("FAIL wr_state got %o exp 03", port_state); n_fail++; end
        n_checks++;
        if (lane_tx_en !== 16'h0000 || port_up !== 2'b00) begin
            $display("FAIL wr_hold_outputs got lane %h up %b exp 0000 00", lane_tx_en, port_up); n_fail++;
        end
        n_checks++;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) tick();
            if (perst_n !== 2'b00 || refclk_oe !== 2'b01) begin
                $display("FAIL wr_hold M+%0d got perst %b refclk %b exp 00 01", i, perst_n, refclk_oe); n_fail++;
            end
            n_checks++;
        end
        tick();                                  // M+5
        if (perst_n !== 2'b01) begin $display("FAIL wr_release got %b exp 01", perst_n); n_fail++; end
        n_checks++;
        // Second pulse two cycles into HOLD restarts the hold time.
        port_rst_req = 2'b01;                    // M
        tick(); port_rst_req = 2'b00;            // M+1
        tick(); port_rst_req = 2'b01;            // M+2
        tick(); port_rst_req = 2'b00;            // M+3
        for (int i = 4; i <= 6; i++) begin
            tick();
            if (perst_n !== 2'b00) begin $display("FAIL wr2_hold M+%0d got %b exp 00", i, perst_n); n_fail++; end
            n_checks++;
        end
        tick();                                  // M+7
        if (perst_n !== 2'b01) begin $display("FAIL wr2_release got %b exp 01", perst_n); n_fail++; end
        n_checks++;
    endtask

    task automatic test_power_down();
        port_en = 2'b00;                         // cycle C
        tick();                                  // C+1
        if (port_state !== 6'o04 || perst_n !== 2'b00 || refclk_oe !== 2'b01) begin
            $display("FAIL pd_enter got state %o perst %b refclk %b exp 04 00 01", port_state, perst_n, refclk_oe); n_fail++;
        end
        n_checks++;
        tick(); port_en = 2'b01;                 // C+2, re-enable must be ignored
        for (int i = 3; i <= 4; i++) begin
            tick();
            if (port_state !== 6'o04 || refclk_oe !== 2'b01) begin
                $display("FAIL pd_down C+%0d got state %o refclk %b exp 04 01", i, port_state, refclk_oe); n_fail++;
            end
            n_checks++;
        end
        tick();                                  // C+5
        if (port_state !== 6'o00 || refclk_oe !== 2'b00) begin
            $display("FAIL pd_off got state %o refclk %b exp 00 00", port_state, refclk_oe); n_fail++;
        end
        n_checks++;
        tick();                                  // C+6
        if (port_state !== 6'o01) begin $display("FAIL pd_reseq got %o exp 01", port_state); n_fail++; end
        n_checks++;
        port_en = 2'b11;
        for (int i = 0; i < 10; i++) tick();
        if (port_up !== 2'b11 || lane_tx_en !== 16'hFFFF) begin
            $display("FAIL both_up got up %b lane %h exp 11 ffff", port_up, lane_tx_en); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_power_fail();
        lane_mask = 16'hA5FF;
        pwr_ok = 1'b0;                           // cycle P
        tick();                                  // P+1
        if (perst_n !== 2'b00 || refclk_oe !== 2'b00 || lane_tx_en !== 16'h0000 || port_state !== 6'o00) begin
            $display("FAIL pf_off got perst %b refclk %b lane %h state %o exp 00 00 0000 00",
                     perst_n, refclk_oe, lane_tx_en, port_state); n_fail++;
        end
        n_checks++;
        tick();
        if (port_state !== 6'o00) begin $display("FAIL pf_hold_off got %o exp 00", port_state); n_fail++; end
        n_checks++;
        pwr_ok = 1'b1;                           // Q
        tick();                                  // Q+1
        if (port_state !== 6'o11 || refclk_oe !== 2'b11) begin
            $display("FAIL pf_reseq got state %o refclk %b exp 11 11", port_state, refclk_oe); n_fail++;
        end
        n_checks++;
        for (int i = 2; i <= 5; i++) begin
            tick();
            if (perst_n !== 2'b00) begin $display("FAIL pf_full_wait Q+%0d got %b exp 00", i, perst_n); n_fail++; end
            n_checks++;
        end
        tick();                                  // Q+6
        if (perst_n !== 2'b11 || lane_tx_en !== 16'hA5FF) begin
            $display("FAIL pf_up got perst %b lane %h exp 11 a5ff", perst_n, lane_tx_en); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_priority();
        port_en = 2'b10; port_rst_req = 2'b01;   // disable and reset together
        tick(); port_rst_req = 2'b00;
        if (port_state !== 6'o24) begin $display("FAIL prio_down got %o exp 24", port_state); n_fail++; end
        n_checks++;
        for (int i = 0; i < 4; i++) tick();
        if (port_state !== 6'o20) begin $display("FAIL prio_off got %o exp 20", port_state); n_fail++; end
        n_checks++;
        port_en = 2'b11;
        tick();
        port_en = 2'b10;                         // abort during CLK_WAIT
        tick();
        if (port_state !== 6'o20 || refclk_oe !== 2'b10) begin
            $display("FAIL cw_abort got state %o refclk %b exp 20 10", port_state, refclk_oe); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_rst_mid();
        port_en = 2'b11;
        tick();
        rst = 1'b1;                              // port 0 in CLK_WAIT
        tick();
        if (perst_n !== 2'b00 || refclk_oe !== 2'b00 || lane_tx_en !== 16'h0000 || port_up !== 2'b00 || port_state !== 6'o00) begin
            $display("FAIL rst_cw got perst %b refclk %b lane %h up %b state %o exp all 0",
                     perst_n, refclk_oe, lane_tx_en, port_up, port_state); n_fail++;
        end
        n_checks++;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        port_rst_req = 2'b10;
        tick(); port_rst_req = 2'b00;
        if (port_state !== 6'o32) begin $display("FAIL rst_pre_hold got %o exp 32", port_state); n_fail++; end
        n_checks++;
        rst = 1'b1;                              // port 1 in HOLD
        tick();
        if (perst_n !== 2'b00 || refclk_oe !== 2'b00 || lane_tx_en !== 16'h0000 || port_up !== 2'b00 || port_state !== 6'o00) begin
            $display("FAIL rst_hold got perst %b refclk %b lane %h up %b state %o exp all 0",
                     perst_n, refclk_oe, lane_tx_en, port_up, port_state); n_fail++;
        end
        n_checks++;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_lane_mask();
        test_warm_reset();
        test_power_down();
        test_power_fail();
        test_priority();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
